calc_op_arbiter: RTL and testbench

- Shares one calculator execution unit (add/subtract/multiply) between NUM_REQ requesters using round-robin arbitration.
- Captures the winning requester's opcode and operands, then sequences execution: single-cycle add/sub, or a WIDTH-cycle shift-add multiply.
- Returns the result with the requester index.
- Sits between the operand/opcode sources and the result display/register logic.

---
 rtl/calc_op_arbiter.sv | 200 ++++++++++++++++++++
 tb/tb_calc_op_arbiter.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/calc_op_arbiter.sv
// Round-robin arbiter in front of one shared add/subtract/multiply unit.
// Captures the winner's operands, runs the operation, returns result with owner index.
module calc_op_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = 8,
    parameter int IDW     = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_REQ-1:0]       req_valid,
    input  logic [2*NUM_REQ-1:0]     req_op,
    input  logic [WIDTH*NUM_REQ-1:0] req_a,
    input  logic [WIDTH*NUM_REQ-1:0] req_b,
    output logic [NUM_REQ-1:0]       grant,
    output logic                     busy,
    output logic                     done,
    output logic [IDW-1:0]           done_id,
    output logic [2*WIDTH-1:0]       result,
    output logic                     err
);

    typedef enum logic [1:0] {IDLE, EXEC, MUL, DONE} state_t;

    localparam int CW  = $clog2(WIDTH + 1);
    localparam int IW1 = IDW + 1;
    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_MUL = 2'b10;

    state_t               state_q, state_d;
    logic [IDW-1:0]       ptr_q, ptr_d;
    logic [IDW-1:0]       id_q, id_d;
    logic [1:0]           op_q, op_d;
    logic [2*WIDTH-1:0]   mcand_q, mcand_d;
    logic [WIDTH-1:0]     mplier_q, mplier_d;
    logic [2*WIDTH-1:0]   acc_q, acc_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [NUM_REQ-1:0]   grant_q, grant_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic [IDW-1:0]       done_id_q, done_id_d;
    logic [2*WIDTH-1:0]   result_q, result_d;
    logic                 err_q, err_d;

    logic [1:0]           op_arr [NUM_REQ];
    logic [WIDTH-1:0]     a_arr  [NUM_REQ];
    logic [WIDTH-1:0]     b_arr  [NUM_REQ];

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
            assign op_arr[gi] = req_op[2*gi +: 2];
            assign a_arr[gi]  = req_a[WIDTH*gi +: WIDTH];
            assign b_arr[gi]  = req_b[WIDTH*gi +: WIDTH];
        end
    endgenerate

    // Winner is the first requester at or above the pointer, wrapping around.
    logic           found;
    logic [IDW-1:0] win;
    logic [IDW-1:0] cand;
    logic [IDW:0]   idx;

    always_comb begin
        found = 1'b0;
        win   = '0;
        cand  = '0;
        idx   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = {1'b0, ptr_q} + IW1'(k);
            if (idx >= IW1'(NUM_REQ)) begin
                idx = idx - IW1'(NUM_REQ);
            end
            cand = idx[IDW-1:0];
            if (!found && req_valid[cand]) begin
                found = 1'b1;
                win   = cand;
            end
        end
    end

    logic [WIDTH:0]     sum_w;
    logic [WIDTH:0]     diff_w;
    logic [2*WIDTH-1:0] addend_w;

    assign sum_w    = {1'b0, mcand_q[WIDTH-1:0]} + {1'b0, mplier_q};
    assign diff_w   = {1'b0, mcand_q[WIDTH-1:0]} - {1'b0, mplier_q};
    assign addend_w = mplier_q[0] ? mcand_q : '0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            ptr_q     <= '0;
            id_q      <= '0;
            op_q      <= '0;
            mcand_q   <= '0;
            mplier_q  <= '0;
            acc_q     <= '0;
            cnt_q     <= '0;
            grant_q   <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            done_id_q <= '0;
            result_q  <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            id_q      <= id_d;
            op_q      <= op_d;
            mcand_q   <= mcand_d;
            mplier_q  <= mplier_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            grant_q   <= grant_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            done_id_q <= done_id_d;
            result_q  <= result_d;
            err_q     <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (found) state_d = EXEC;
            EXEC:    state_d = (op_q == OP_MUL) ? MUL : DONE;
            MUL:     if (cnt_q == CW'(1)) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        ptr_d     = ptr_q;
        id_d      = id_q;
        op_d      = op_q;
        mcand_d   = mcand_q;
        mplier_d  = mplier_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        grant_d   = '0;
        done_d    = 1'b0;
        done_id_d = done_id_q;
        result_d  = result_q;
        err_d     = err_q;
        case (state_q)
            IDLE: begin
                if (found) begin
                    grant_d  = NUM_REQ'(1) << win;
                    ptr_d    = (win == IDW'(NUM_REQ - 1)) ? '0 : win + IDW'(1);
                    id_d     = win;
                    op_d     = op_arr[win];
                    mcand_d  = {{WIDTH{1'b0}}, a_arr[win]};
                    mplier_d = b_arr[win];
                end
            end
            EXEC: begin
                if (op_q == OP_MUL) begin
                    acc_d = '0;
                    cnt_d = CW'(WIDTH);
                end else begin
                    done_d    = 1'b1;
                    done_id_d = id_q;
                    err_d     = 1'b0;
                    if (op_q == OP_ADD) begin
                        result_d = {{(WIDTH-1){1'b0}}, sum_w};
                    end else if (op_q == OP_SUB) begin
                        result_d = {{(WIDTH-1){diff_w[WIDTH]}}, diff_w};
                    end else begin
                        result_d = '0;
                        err_d    = 1'b1;
                    end
                end
            end
            MUL: begin
                acc_d    = acc_q + addend_w;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    done_d    = 1'b1;
                    done_id_d = id_q;
                    result_d  = acc_q + addend_w;
                    err_d     = 1'b0;
                end
            end
            default: ;
        endcase
        busy_d = (state_d != IDLE);
    end

    assign grant   = grant_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign done_id = done_id_q;
    assign result  = result_q;
    assign err     = err_q;

endmodule

// File: tb/tb_calc_op_arbiter.sv
// Directed bench for calc_op_arbiter: vector table of single operations plus
// round-robin and mid-multiply reset sequences.
module tb_calc_op_arbiter;
    localparam int NR  = 4;
    localparam int W   = 8;
    localparam int IDW = 2;

    logic              clk = 1'b0;
    logic              reset;
    logic [NR-1:0]     req_valid;
    logic [2*NR-1:0]   req_op;
    logic [W*NR-1:0]   req_a;
    logic [W*NR-1:0]   req_b;
    logic [NR-1:0]     grant;
    logic              busy;
    logic              done;
    logic [IDW-1:0]    done_id;
    logic [2*W-1:0]    result;
    logic              err;

    calc_op_arbiter #(.NUM_REQ(NR), .WIDTH(W), .IDW(IDW)) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_op    (req_op),
        .req_a     (req_a),
        .req_b     (req_b),
        .grant     (grant),
        .busy      (busy),
        .done      (done),
        .done_id   (done_id),
        .result    (result),
        .err       (err)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        int          id;
        logic [1:0]  op;
        logic [7:0]  a;
        logic [7:0]  b;
        logic [15:0] res;
        logic        e;
    } vec_t;

    vec_t vecs [10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int id, input logic [1:0] op, input logic [7:0] a, input logic [7:0] b);
        req_valid[id]      = 1'b1;
        req_op[2*id +: 2]  = op;
        req_a[W*id +: W]   = a;
        req_b[W*id +: W]   = b;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_grant"},   32'(grant),   32'd0);
        chk({tag, "_busy"},    32'(busy),    32'd0);
        chk({tag, "_done"},    32'(done),    32'd0);
        chk({tag, "_done_id"}, 32'(done_id), 32'd0);
        chk({tag, "_result"},  32'(result),  32'd0);
        chk({tag, "_err"},     32'(err),     32'd0);
    endtask

    // Returns the grant vector and how many cycles it took to appear.
    task automatic wait_grant(output logic [NR-1:0] g, output int n);
        logic seen;
        n = 0;
        seen = 1'b0;
        while (!seen && n < 30) begin
            tick();
            n++;
            if (grant != '0) seen = 1'b1;
        end
        chk("grant_seen", 32'(seen), 32'd1);
        g = grant;
    endtask

    // Returns cycles from grant to done; busy must stay high throughout.
    task automatic wait_done(output int n);
        logic seen;
        logic busy_ok;
        n = 0;
        seen = 1'b0;
        busy_ok = 1'b1;
        while (!seen && n < 40) begin
            tick();
            n++;
            if (!busy) busy_ok = 1'b0;
            if (done) seen = 1'b1;
        end
        chk("done_seen", 32'(seen), 32'd1);
        chk("busy_during_op", 32'(busy_ok), 32'd1);
        chk("grant_low_at_done", 32'(grant), 32'd0);
    endtask

    task automatic run_vec(input vec_t v);
        logic [NR-1:0] g;
        int n;
        int lat;
        logic [15:0] res_seen;
        set_req(v.id, v.op, v.a, v.b);
        wait_grant(g, n);
        chk("vec_grant", 32'(g), 32'(1 << v.id));
        req_valid = '0;
        wait_done(n);
        lat = (v.op == 2'b10) ? W + 1 : 1;
        chk("vec_latency", 32'(n), 32'(lat));
        chk("vec_result", 32'(result), 32'(v.res));
        chk("vec_done_id", 32'(done_id), 32'(v.id));
        chk("vec_err", 32'(err), 32'(v.e));
        res_seen = result;
        $display("[TB] id=%0d op=%0d a=%0d b=%0d -> result=0x%04h err=%0b lat=%0d",
                 v.id, v.op, v.a, v.b, res_seen, err, n);
        tick();
        chk("vec_done_pulse", 32'(done), 32'd0);
        chk("vec_busy_after", 32'(busy), 32'd0);
        chk("vec_result_held", 32'(result), 32'(v.res));
    endtask

    initial begin
        logic [NR-1:0] g;
        int n;
        int dones;

        vecs[0] = '{id: 0, op: 2'b00, a: 8'd200, b: 8'd100, res: 16'h012C, e: 1'b0};
        vecs[1] = '{id: 2, op: 2'b01, a: 8'd5,   b: 8'd9,   res: 16'hFFFC, e: 1'b0};
        vecs[2] = '{id: 2, op: 2'b01, a: 8'd9,   b: 8'd5,   res: 16'h0004, e: 1'b0};
        vecs[3] = '{id: 1, op: 2'b10, a: 8'd255, b: 8'd255, res: 16'hFE01, e: 1'b0};
        vecs[4] = '{id: 1, op: 2'b10, a: 8'd0,   b: 8'd77,  res: 16'h0000, e: 1'b0};
        vecs[5] = '{id: 3, op: 2'b11, a: 8'd1,   b: 8'd1,   res: 16'h0000, e: 1'b1};
        vecs[6] = '{id: 3, op: 2'b00, a: 8'd1,   b: 8'd1,   res: 16'h0002, e: 1'b0};
        vecs[7] = '{id: 0, op: 2'b10, a: 8'd13,  b: 8'd11,  res: 16'h008F, e: 1'b0};
        vecs[8] = '{id: 2, op: 2'b00, a: 8'd255, b: 8'd255, res: 16'h01FE, e: 1'b0};
        vecs[9] = '{id: 1, op: 2'b01, a: 8'd0,   b: 8'd255, res: 16'hFF01, e: 1'b0};

        reset     = 1'b1;
        req_valid = '0;
        req_op    = '0;
        req_a     = '0;
        req_b     = '0;
        tick();
        tick();
        check_reset_outputs("reset");
        reset = 1'b0;
        tick();

        for (int i = 0; i < 10; i++) begin
            run_vec(vecs[i]);
        end

        // Round robin with all requesters held continuously.
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int i = 0; i < NR; i++) begin
            set_req(i, 2'b00, 8'(10 + i), 8'(i));
        end
        for (int j = 0; j < 5; j++) begin
            wait_grant(g, n);
            chk("rr_grant", 32'(g), 32'(1 << (j % NR)));
            if (j > 0) chk("rr_gap", 32'(n), 32'd2);
            wait_done(n);
            chk("rr_latency", 32'(n), 32'd1);
            chk("rr_done_id", 32'(done_id), 32'(j % NR));
            chk("rr_result", 32'(result), 32'(10 + 2 * (j % NR)));
            $display("[TB] rr grant=%b done_id=%0d result=%0d", g, done_id, result);
        end
        req_valid = '0;
        tick();
        tick();

        // Reset during multiply cycle 4: no done, pointer back to 0.
        set_req(1, 2'b10, 8'd3, 8'd3);
        wait_grant(g, n);
        chk("mr_grant", 32'(g), 32'b0010);
        req_valid = '0;
        repeat (4) tick();
        chk("mr_busy_before", 32'(busy), 32'd1);
        #2;
        reset = 1'b1;
        #1;
        check_reset_outputs("mr_async");
        tick();
        reset = 1'b0;
        dones = 0;
        repeat (12) begin
            tick();
            if (done) dones++;
        end
        chk("mr_no_done", 32'(dones), 32'd0);
        $display("[TB] reset mid-multiply, dones after release=%0d", dones);

        set_req(1, 2'b00, 8'd1, 8'd1);
        set_req(3, 2'b00, 8'd2, 8'd2);
        wait_grant(g, n);
        chk("mr_ptr_grant1", 32'(g), 32'b0010);
        req_valid[1] = 1'b0;
        wait_done(n);
        chk("mr_result1", 32'(result), 32'd2);
        chk("mr_id1", 32'(done_id), 32'd1);
        wait_grant(g, n);
        chk("mr_ptr_grant3", 32'(g), 32'b1000);
        req_valid[3] = 1'b0;
        wait_done(n);
        chk("mr_result3", 32'(result), 32'd4);
        chk("mr_id3", 32'(done_id), 32'd3);
        $display("[TB] post-reset pair id1->2, id3->%0d", result);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
